// File: rtl/iomem_arb_pkg.sv
// rtl/iomem_arb_pkg.sv - shared state encoding, counter width and RAM window decode
package iomem_arb_pkg;

  localparam int CNT_W = $clog2(256);

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_RESP = 2'd2;
  localparam arb_state_t ST_ERR  = 2'd3;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/iomem_mem_arbiter_if.sv
// rtl/iomem_mem_arbiter_if.sv - iomem-style request/response bundle for one requester
interface iomem_mem_arbiter_if;

  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/iomem_mem_arbiter_rr_arbiter_2.sv
// rtl/iomem_mem_arbiter_rr_arbiter_2.sv - two-input round-robin grant with last-grant memory
module rr_arbiter_2 (
  input  logic       clk_wiz_o,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic last_d;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_idx_o = ~last_q;
    end else begin
      gnt_idx_o = ~req_i[0];
    end
    last_d = last_q;
    if (en_i && gnt_valid_o) begin
      last_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/iomem_mem_arbiter.sv
// rtl/iomem_mem_arbiter.sv - shares the single-port RAM between two iomem requesters
module iomem_mem_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int          RAM_DELAY     = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff,
  parameter logic [31:0] ERR_RDATA     = 32'h0000_0000
) (
  input  logic                       clk_wiz_o,
  input  logic                       rst_n,
  iomem_mem_arbiter_if.slave         m0,
  iomem_mem_arbiter_if.slave         m1,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic                       mem_rd_en,
  input  logic [31:0]                mem_rdata,
  output logic                       busy_o,
  output logic                       grant_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_DELAY - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             first_q, first_d;
  logic [31:0]      resp_q, resp_d;
  logic             grant_q, grant_d;

  logic             gnt_valid;
  logic             gnt_idx;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;

  logic             in_busy;
  logic             in_done;
  logic [31:0]      resp_data;
  logic             ready0;
  logic             ready1;

  rr_arbiter_2 u_rr (
    .clk_wiz_o   (clk_wiz_o),
    .rst_n       (rst_n),
    .en_i        (state_q == ST_IDLE),
    .req_i       ({m1.valid, m0.valid}),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign req_addr  = gnt_idx ? m1.addr  : m0.addr;
  assign req_wdata = gnt_idx ? m1.wdata : m0.wdata;
  assign req_wstrb = gnt_idx ? m1.wstrb : m0.wstrb;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    first_d = 1'b0;
    resp_d  = resp_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          grant_d = gnt_idx;
          if (in_window(req_addr, RAM_BASE_ADDR, RAM_MASK_ADDR)) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
            first_d = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          resp_d  = (wstrb_q == 4'b0000) ? mem_rdata : 32'h0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      first_q <= 1'b0;
      resp_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      first_q <= first_d;
      resp_q  <= resp_d;
      grant_q <= grant_d;
    end
  end

  // RAM side is quiet outside BUSY; the write strobe fires only once per transaction.
  assign in_busy   = (state_q == ST_BUSY);
  assign in_done   = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign mem_addr  = in_busy ? addr_q  : 32'h0;
  assign mem_wdata = in_busy ? wdata_q : 32'h0;
  assign mem_wstrb = (in_busy && first_q) ? wstrb_q : 4'b0000;
  assign mem_rd_en = in_busy && (wstrb_q == 4'b0000);
  assign busy_o    = in_busy;
  assign grant_o   = grant_q;

  assign resp_data = (state_q == ST_ERR) ? ERR_RDATA : resp_q;
  assign ready0    = in_done && !grant_q;
  assign ready1    = in_done &&  grant_q;

  assign m0.ready  = ready0;
  assign m1.ready  = ready1;
  assign m0.rdata  = ready0 ? resp_data : 32'h0;
  assign m1.rdata  = ready1 ? resp_data : 32'h0;

endmodule

// File: tb/tb_iomem_mem_arbiter.sv
// tb/tb_iomem_mem_arbiter.sv - scoreboard bench for the iomem RAM arbiter
`timescale 1ns/1ps
module tb_iomem_mem_arbiter;

  typedef struct packed {
    logic        mst;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ram_init;
  always #5 clk = ~clk;

  iomem_mem_arbiter_if m0_if ();
  iomem_mem_arbiter_if m1_if ();
  iomem_mem_arbiter_if m0b_if ();
  iomem_mem_arbiter_if m1b_if ();

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rd_en, busy, grant;
  logic [31:0] mem2_addr, mem2_wdata, mem2_rdata;
  logic [3:0]  mem2_wstrb;
  logic        mem2_rd_en, busy2, grant2;

  iomem_mem_arbiter #(.RAM_DELAY(16)) dut (
    .clk_wiz_o (clk),       .rst_n     (rst_n),
    .m0        (m0_if),     .m1        (m1_if),
    .mem_addr  (mem_addr),  .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb), .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata), .busy_o    (busy),
    .grant_o   (grant)
  );

  iomem_mem_arbiter #(.RAM_DELAY(2)) dut2 (
    .clk_wiz_o (clk),        .rst_n     (rst_n),
    .m0        (m0b_if),     .m1        (m1b_if),
    .mem_addr  (mem2_addr),  .mem_wdata (mem2_wdata),
    .mem_wstrb (mem2_wstrb), .mem_rd_en (mem2_rd_en),
    .mem_rdata (mem2_rdata), .busy_o    (busy2),
    .grant_o   (grant2)
  );

  logic [31:0] ram [0:255];
  assign mem_rdata  = ram[mem_addr[9:2]];
  assign mem2_rdata = ram[mem2_addr[9:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      ram[4]  <= 32'hCAFE_0001;
      ram[8]  <= 32'hAAAA_BBBB;
      ram[12] <= 32'h0000_3333;
    end else if (mem_wstrb != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int cyc = 0;
  int rd_cnt = 0, wst_cnt = 0, busy_cnt = 0, r0_cnt = 0, r1_cnt = 0;
  logic [3:0] last_wst = 4'b0000;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wstrb != 4'b0000) begin
      wst_cnt  <= wst_cnt + 1;
      last_wst <= mem_wstrb;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (m0_if.ready) r0_cnt <= r0_cnt + 1;
    if (m1_if.ready) r1_cnt <= r1_cnt + 1;
  end

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic wait_ready(input bit sel2, output bit mst, output logic [31:0] data,
                            output int at, output bit ok);
    ok = 1'b0; mst = 1'b0; data = 32'h0; at = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!sel2) begin
        if (m0_if.ready) begin ok = 1'b1; mst = 1'b0; data = m0_if.rdata; end
        else if (m1_if.ready) begin ok = 1'b1; mst = 1'b1; data = m1_if.rdata; end
      end else begin
        if (m0b_if.ready) begin ok = 1'b1; mst = 1'b0; data = m0b_if.rdata; end
        else if (m1b_if.ready) begin ok = 1'b1; mst = 1'b1; data = m1b_if.rdata; end
      end
      if (ok) at = cyc;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ram_init = 1'b1;
    {m0_if.valid, m1_if.valid, m0b_if.valid, m1b_if.valid} = 4'b0;
    m0_if.addr = 0; m0_if.wdata = 0; m0_if.wstrb = 0;
    m1_if.addr = 0; m1_if.wdata = 0; m1_if.wstrb = 0;
    m0b_if.addr = 0; m0b_if.wdata = 0; m0b_if.wstrb = 0;
    m1b_if.addr = 0; m1b_if.wdata = 0; m1b_if.wstrb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m0_if.ready, m1_if.ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {m0_if.ready, m1_if.ready});
    end
    checks++;
    if ((m0_if.rdata | m1_if.rdata) !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 0", m0_if.rdata | m1_if.rdata);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({mem_wstrb, mem_rd_en, busy, grant} !== 7'h0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {mem_wstrb, mem_rd_en, busy, grant});
    end
    checks++;
    if ({mem2_wstrb, mem2_rd_en, busy2, grant2} !== 7'h0) begin
      errors++; $display("FAIL reset_ctrl_d2 got %b exp 0", {mem2_wstrb, mem2_rd_en, busy2, grant2});
    end
    @(posedge clk); #1;
    ram_init = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    bit mst, ok; logic [31:0] d; int at, t0, rd0, ws0, r1_0; exp_t e;
    @(posedge clk); #1;
    rd0 = rd_cnt; ws0 = wst_cnt; r1_0 = r1_cnt;
    m0_if.addr = 32'h4000_0010; m0_if.wstrb = 4'b0000; m0_if.valid = 1'b1; t0 = cyc;
    sb.push_back({1'b0, 32'hCAFE_0001});
    wait_ready(1'b0, mst, d, at, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_timeout got none exp ready"); end
    e = sb.pop_front();
    checks++;
    if ({mst, d} !== {e.mst, e.data}) begin
      errors++; $display("FAIL read_data got %0d/%h exp %0d/%h", mst, d, e.mst, e.data);
    end
    checks++;
    if (at - t0 !== 17) begin errors++; $display("FAIL read_latency got %0d exp 17", at - t0); end
    checks++;
    if ({m1_if.ready, m1_if.rdata} !== 33'h0) begin
      errors++; $display("FAIL read_other_master got %h exp 0", {m1_if.ready, m1_if.rdata});
    end
    @(posedge clk); #1;
    m0_if.valid = 1'b0;
    checks++;
    if (rd_cnt - rd0 !== 16) begin errors++; $display("FAIL read_rd_en_cycles got %0d exp 16", rd_cnt - rd0); end
    checks++;
    if ((wst_cnt - ws0) + (r1_cnt - r1_0) !== 0) begin
      errors++; $display("FAIL read_side_effects got %0d exp 0", (wst_cnt - ws0) + (r1_cnt - r1_0));
    end
  endtask

  task automatic test_write;
    bit mst, ok; logic [31:0] d; int at, t0, rd0, ws0, r0_0; exp_t e;
    @(posedge clk); #1;
    rd0 = rd_cnt; ws0 = wst_cnt; r0_0 = r0_cnt;
    m1_if.addr = 32'h4000_0020; m1_if.wdata = 32'h1234_5678; m1_if.wstrb = 4'b0011;
    m1_if.valid = 1'b1; t0 = cyc;
    sb.push_back({1'b1, 32'h0});
    wait_ready(1'b0, mst, d, at, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_timeout got none exp ready"); end
    e = sb.pop_front();
    checks++;
    if ({mst, d} !== {e.mst, e.data}) begin
      errors++; $display("FAIL write_resp got %0d/%h exp %0d/%h", mst, d, e.mst, e.data);
    end
    checks++;
    if (at - t0 !== 17) begin errors++; $display("FAIL write_latency got %0d exp 17", at - t0); end
    @(posedge clk); #1;
    m1_if.valid = 1'b0;
    checks++;
    if (wst_cnt - ws0 !== 1 || last_wst !== 4'b0011) begin
      errors++; $display("FAIL write_strobe got %0d/%b exp 1/0011", wst_cnt - ws0, last_wst);
    end
    checks++;
    if ((rd_cnt - rd0) + (r0_cnt - r0_0) !== 0) begin
      errors++; $display("FAIL write_side_effects got %0d exp 0", (rd_cnt - rd0) + (r0_cnt - r0_0));
    end
    @(posedge clk); #1;
    m0_if.addr = 32'h4000_0020; m0_if.wstrb = 4'b0000; m0_if.valid = 1'b1;
    sb.push_back({1'b0, 32'hAAAA_5678});
    wait_ready(1'b0, mst, d, at, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || d[15:0] !== 16'h5678) begin
      errors++; $display("FAIL readback_low got %h exp 5678", d[15:0]);
    end
    checks++;
    if ({mst, d} !== {e.mst, e.data}) begin
      errors++; $display("FAIL readback_word got %0d/%h exp %0d/%h", mst, d, e.mst, e.data);
    end
    @(posedge clk); #1;
    m0_if.valid = 1'b0;
  endtask

  task automatic test_error;
    bit mst, ok; logic [31:0] d; int at, t0, rd0, ws0, bz0; exp_t e;
    @(posedge clk); #1;
    rd0 = rd_cnt; ws0 = wst_cnt; bz0 = busy_cnt;
    m0_if.addr = 32'h5000_0000; m0_if.wstrb = 4'b0000; m0_if.valid = 1'b1; t0 = cyc;
    sb.push_back({1'b0, 32'h0});
    wait_ready(1'b0, mst, d, at, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {mst, d} !== {e.mst, e.data}) begin
      errors++; $display("FAIL err_resp got %0d/%h exp %0d/%h", mst, d, e.mst, e.data);
    end
    checks++;
    if (at - t0 !== 1) begin errors++; $display("FAIL err_latency got %0d exp 1", at - t0); end
    @(posedge clk); #1;
    m0_if.valid = 1'b0;
    checks++;
    if ((rd_cnt - rd0) + (wst_cnt - ws0) + (busy_cnt - bz0) !== 0) begin
      errors++; $display("FAIL err_mem_activity got %0d exp 0", (rd_cnt - rd0) + (wst_cnt - ws0) + (busy_cnt - bz0));
    end
  endtask

  task automatic test_reset_mid;
    bit mst, ok; logic [31:0] d; int at, t0, ws0, r0_0; exp_t e;
    @(posedge clk); #1;
    ws0 = wst_cnt; r0_0 = r0_cnt;
    m0_if.addr = 32'h4000_0040; m0_if.wdata = 32'hDEAD_BEEF; m0_if.wstrb = 4'b1111;
    m0_if.valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", busy); end
    rst_n = 1'b0; m0_if.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, mem_rd_en, busy, grant, m0_if.ready, m1_if.ready} !== 74'h0) begin
      errors++; $display("FAIL midrst_outputs got %h exp 0",
        {mem_addr, mem_wdata, mem_wstrb, mem_rd_en, busy, grant, m0_if.ready, m1_if.ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (r0_cnt - r0_0 !== 0) begin errors++; $display("FAIL midrst_no_ready got %0d exp 0", r0_cnt - r0_0); end
    checks++;
    if (wst_cnt - ws0 !== 1) begin errors++; $display("FAIL midrst_strobe_once got %0d exp 1", wst_cnt - ws0); end
    m1_if.addr = 32'h4000_0010; m1_if.wstrb = 4'b0000; m1_if.valid = 1'b1; t0 = cyc;
    sb.push_back({1'b1, 32'hCAFE_0001});
    wait_ready(1'b0, mst, d, at, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {mst, d} !== {e.mst, e.data} || at - t0 !== 17) begin
      errors++; $display("FAIL midrst_recover got %0d/%h lat %0d exp %0d/%h lat 17", mst, d, at - t0, e.mst, e.data);
    end
    @(posedge clk); #1;
    m1_if.valid = 1'b0;
  endtask

  task automatic test_fairness;
    bit mst, ok; logic [31:0] d; int at, prev, t0; exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m0_if.addr = 32'h4000_0010; m0_if.wstrb = 4'b0000; m0_if.valid = 1'b1;
    m1_if.addr = 32'h4000_0030; m1_if.wstrb = 4'b0000; m1_if.valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({1'b0, 32'hCAFE_0001});
      sb.push_back({1'b1, 32'h0000_3333});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; t0 = cyc; prev = t0 - 1;
    for (int i = 0; i < 4; i++) begin
      wait_ready(1'b0, mst, d, at, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {mst, d} !== {e.mst, e.data} || grant !== e.mst) begin
        errors++; $display("FAIL rr_order%0d got %0d/%h grant %b exp %0d/%h", i, mst, d, grant, e.mst, e.data);
      end
      checks++;
      if (at - prev !== 18) begin
        errors++; $display("FAIL rr_spacing%0d got %0d exp 18", i, at - prev);
      end
      prev = at;
    end
    @(posedge clk); #1;
    m0_if.valid = 1'b0; m1_if.valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit mst, ok; logic [31:0] d; int at, t0, first_at; exp_t e;
    @(posedge clk); #1;
    m0b_if.addr = 32'h4000_0010; m0b_if.wstrb = 4'b0000; m0b_if.valid = 1'b1; t0 = cyc;
    sb.push_back({1'b0, 32'hCAFE_0001});
    sb.push_back({1'b0, 32'hCAFE_0001});
    wait_ready(1'b1, mst, d, at, ok);
    first_at = at;
    e = sb.pop_front();
    checks++;
    if (!ok || {mst, d} !== {e.mst, e.data} || at - t0 !== 3) begin
      errors++; $display("FAIL b2b_first got %0d/%h lat %0d exp %0d/%h lat 3", mst, d, at - t0, e.mst, e.data);
    end
    wait_ready(1'b1, mst, d, at, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {mst, d} !== {e.mst, e.data}) begin
      errors++; $display("FAIL b2b_second got %0d/%h exp %0d/%h", mst, d, e.mst, e.data);
    end
    checks++;
    if (at - first_at !== 4) begin errors++; $display("FAIL b2b_spacing got %0d exp 4", at - first_at); end
    @(posedge clk); #1;
    m0b_if.valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error();
    test_reset_mid();
    test_fairness();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
